// File: rtl/opb_master_pkg.sv
// Shared types and constants for the single-transaction OPB master bridge.
package opb_master_pkg;

    localparam int unsigned C_OPB_AWIDTH_DFLT = 32;
    localparam int unsigned C_OPB_DWIDTH_DFLT = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        XFER,
        BACKOFF,
        RESP
    } state_t;

    localparam logic [1:0] ST_OK         = 2'd0;
    localparam logic [1:0] ST_ERR        = 2'd1;
    localparam logic [1:0] ST_TIMEOUT    = 2'd2;
    localparam logic [1:0] ST_RETRY_FAIL = 2'd3;

endpackage

// File: rtl/opb_master_wdog.sv
// Loadable cycle counter that saturates at TERMINAL and flags it on tc.
module opb_master_wdog #(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned TERMINAL = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;

    assign tc  = (cnt_q == WIDTH'(TERMINAL));
    assign cnt = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/opb_master_cmd_bridge.sv
// Single-command OPB master: takes one user read/write, runs it on OPB, returns data and status.
module opb_master_cmd_bridge
    import opb_master_pkg::*;
#(
    parameter int unsigned C_OPB_AWIDTH  = C_OPB_AWIDTH_DFLT,
    parameter int unsigned C_OPB_DWIDTH  = C_OPB_DWIDTH_DFLT,
    parameter string       C_FAMILY      = "virtex6",
    parameter int unsigned C_MAX_RETRY   = 4,
    parameter int unsigned C_WDOG_CYCLES = 32
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    output logic                    M_request,
    output logic                    M_busLock,
    output logic                    M_select,
    output logic                    M_RNW,
    output logic [0:3]              M_BE,
    output logic                    M_seqAddr,
    output logic [0:C_OPB_AWIDTH-1] M_ABus,
    output logic [0:C_OPB_DWIDTH-1] M_DBus,
    input  logic                    OPB_MGrant,
    input  logic                    OPB_xferAck,
    input  logic                    OPB_errAck,
    input  logic                    OPB_retry,
    input  logic                    OPB_timeout,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rnw,
    input  logic [31:0]             cmd_addr,
    input  logic [31:0]             cmd_wdata,
    input  logic [3:0]              cmd_be,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic [1:0]              rsp_status
);

    localparam int unsigned WdogW = $clog2(C_WDOG_CYCLES);

    state_t      state_q, state_d;
    logic        rnw_q, rnw_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [3:0]  retry_q, retry_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  status_q, status_d;

    logic [WdogW-1:0] wdog_cnt;
    logic             wdog_tc;
    logic             in_xfer;

    assign in_xfer = (state_q == XFER);

    opb_master_wdog #(
        .WIDTH    (WdogW),
        .TERMINAL (C_WDOG_CYCLES - 1)
    ) u_wdog (
        .clk      (OPB_Clk),
        .rst      (OPB_Rst),
        .clr      (!in_xfer),
        .load     (1'b0),
        .load_val ('0),
        .en       (in_xfer),
        .cnt      (wdog_cnt),
        .tc       (wdog_tc)
    );

    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_q  <= IDLE;
            rnw_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            retry_q  <= '0;
            rdata_q  <= '0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            rnw_q    <= rnw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            retry_q  <= retry_d;
            rdata_q  <= rdata_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        retry_d  = retry_q;
        rdata_d  = rdata_q;
        status_d = status_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    rnw_d   = cmd_rnw;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    be_d    = cmd_be;
                    retry_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (OPB_MGrant) state_d = XFER;
            end
            XFER: begin
                // Response priority: errAck, xferAck, retry, then timeout/watchdog.
                if (OPB_errAck) begin
                    status_d = ST_ERR;
                    rdata_d  = '0;
                    state_d  = RESP;
                end else if (OPB_xferAck) begin
                    status_d = ST_OK;
                    rdata_d  = rnw_q ? OPB_DBus : '0;
                    state_d  = RESP;
                end else if (OPB_retry) begin
                    if (retry_q == 4'(C_MAX_RETRY)) begin
                        status_d = ST_RETRY_FAIL;
                        rdata_d  = '0;
                        state_d  = RESP;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = BACKOFF;
                    end
                end else if (OPB_timeout || wdog_tc) begin
                    status_d = ST_TIMEOUT;
                    rdata_d  = '0;
                    state_d  = RESP;
                end
            end
            BACKOFF: state_d = REQ;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are zero whenever the master does not own the data phase (OR-bus).
    assign M_busLock  = 1'b0;
    assign M_seqAddr  = 1'b0;
    assign M_request  = (state_q == REQ);
    assign M_select   = in_xfer;
    assign M_RNW      = in_xfer & rnw_q;
    assign M_BE       = in_xfer ? be_q : 4'b0;
    assign M_ABus     = in_xfer ? addr_q : '0;
    assign M_DBus     = (in_xfer && !rnw_q) ? wdata_q : '0;
    assign cmd_ready  = (state_q == IDLE) && !OPB_Rst;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_status = status_q;

endmodule

// File: tb/tb_opb_master_cmd_bridge.sv
// Directed bench for opb_master_cmd_bridge with hand-computed expectations.
module tb_opb_master_cmd_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_request, m_buslock, m_select, m_rnw, m_seqaddr;
    logic [0:3]  m_be;
    logic [0:31] m_abus, m_dbus;
    logic        grant, xfer_ack, err_ack, retry, timeout;
    logic [0:31] opb_dbus;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    opb_master_cmd_bridge dut (
        .OPB_Clk     (clk),
        .OPB_Rst     (rst),
        .M_request   (m_request),
        .M_busLock   (m_buslock),
        .M_select    (m_select),
        .M_RNW       (m_rnw),
        .M_BE        (m_be),
        .M_seqAddr   (m_seqaddr),
        .M_ABus      (m_abus),
        .M_DBus      (m_dbus),
        .OPB_MGrant  (grant),
        .OPB_xferAck (xfer_ack),
        .OPB_errAck  (err_ack),
        .OPB_retry   (retry),
        .OPB_timeout (timeout),
        .OPB_DBus    (opb_dbus),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_rnw     (cmd_rnw),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_be      (cmd_be),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_status  (rsp_status)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_rnw   = rnw;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_be    = 4'hF;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic grant_now();
        grant = 1'b1;
        tick();
        grant = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL time_limit: observed no finish expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; grant = 0; xfer_ack = 0; err_ack = 0; retry = 0; timeout = 0;
        opb_dbus = '0; cmd_valid = 0; cmd_rnw = 0; cmd_addr = '0; cmd_wdata = '0; cmd_be = '0;
        tick();
        tick();
        check("rst_request", 32'(m_request), 0);
        check("rst_select", 32'(m_select), 0);
        check("rst_abus", m_abus, 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_lock_seq", {30'b0, m_buslock, m_seqaddr}, 0);
        rst = 1'b0;
        #1;
        check("idle_ready", 32'(cmd_ready), 1);

        // Best-case write.
        issue(1'b0, 32'h0100_0100, 32'hDEAD_BEEF);
        check("wr_req", 32'(m_request), 1);
        check("wr_ready_low", 32'(cmd_ready), 0);
        check("wr_sel_low_in_req", 32'(m_select), 0);
        grant_now();
        check("wr_select", 32'(m_select), 1);
        check("wr_req_drop", 32'(m_request), 0);
        check("wr_abus", m_abus, 32'h0100_0100);
        check("wr_dbus", m_dbus, 32'hDEAD_BEEF);
        check("wr_be", 32'(m_be), 32'hF);
        check("wr_rnw", 32'(m_rnw), 0);
        xfer_ack = 1'b1;
        tick();
        xfer_ack = 1'b0;
        check("wr_rsp_valid", 32'(rsp_valid), 1);
        check("wr_status", 32'(rsp_status), 0);
        check("wr_abus_gone", m_abus, 0);
        check("wr_dbus_gone", m_dbus, 0);
        tick();
        check("wr_rsp_pulse", 32'(rsp_valid), 0);
        check("wr_back_idle", 32'(cmd_ready), 1);

        // Read with delayed grant, ack on third XFER cycle.
        issue(1'b1, 32'h0100_0104, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            check("rd_wait_req", 32'(m_request), 1);
            tick();
        end
        grant_now();
        check("rd_select", 32'(m_select), 1);
        check("rd_rnw", 32'(m_rnw), 1);
        check("rd_abus", m_abus, 32'h0100_0104);
        check("rd_dbus_zero1", m_dbus, 0);
        tick();
        check("rd_dbus_zero2", m_dbus, 0);
        tick();
        check("rd_dbus_zero3", m_dbus, 0);
        xfer_ack = 1'b1;
        opb_dbus = 32'h1234_5678;
        tick();
        xfer_ack = 1'b0;
        opb_dbus = '0;
        check("rd_rsp_valid", 32'(rsp_valid), 1);
        check("rd_rdata", rsp_rdata, 32'h1234_5678);
        check("rd_status", 32'(rsp_status), 0);
        tick();
        check("rd_rdata_hold", rsp_rdata, 32'h1234_5678);

        // Two retries then ack.
        issue(1'b0, 32'h0100_0108, 32'h0000_00A5);
        for (int i = 0; i < 2; i++) begin
            grant_now();
            check("rt_select", 32'(m_select), 1);
            retry = 1'b1;
            tick();
            retry = 1'b0;
            check("rt_backoff_sel", 32'(m_select), 0);
            check("rt_backoff_req", 32'(m_request), 0);
            tick();
            check("rt_rereq", 32'(m_request), 1);
        end
        grant_now();
        check("rt_select3", 32'(m_select), 1);
        check("rt_dbus3", m_dbus, 32'h0000_00A5);
        xfer_ack = 1'b1;
        tick();
        xfer_ack = 1'b0;
        check("rt_rsp_valid", 32'(rsp_valid), 1);
        check("rt_status", 32'(rsp_status), 0);
        check("rt_rdata_wr", rsp_rdata, 0);
        tick();

        // Five retries exhaust C_MAX_RETRY=4.
        issue(1'b0, 32'h0100_010C, 32'h5555_AAAA);
        for (int i = 0; i < 5; i++) begin
            grant_now();
            check("rf_select", 32'(m_select), 1);
            retry = 1'b1;
            tick();
            retry = 1'b0;
            if (i < 4) begin
                check("rf_backoff_rsp", 32'(rsp_valid), 0);
                tick();
                check("rf_rereq", 32'(m_request), 1);
            end else begin
                check("rf_rsp_valid", 32'(rsp_valid), 1);
                check("rf_status", 32'(rsp_status), 3);
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rf_no_6th_req", 32'(m_request), 0);
        end
        check("rf_idle", 32'(cmd_ready), 1);

        // Watchdog: 32 silent XFER cycles.
        issue(1'b1, 32'h0100_0110, 32'h0);
        grant_now();
        for (int i = 0; i < 31; i++) begin
            check("wd_still_xfer", 32'(m_select), 1);
            tick();
        end
        check("wd_last_xfer", 32'(m_select), 1);
        tick();
        check("wd_rsp_valid", 32'(rsp_valid), 1);
        check("wd_status", 32'(rsp_status), 2);
        tick();

        // Arbiter timeout input.
        issue(1'b1, 32'h0100_0114, 32'h0);
        grant_now();
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        check("to_rsp_valid", 32'(rsp_valid), 1);
        check("to_status", 32'(rsp_status), 2);
        tick();

        // errAck beats xferAck.
        issue(1'b1, 32'h0100_0118, 32'h0);
        grant_now();
        err_ack = 1'b1; xfer_ack = 1'b1; opb_dbus = 32'hCAFE_F00D;
        tick();
        err_ack = 1'b0; xfer_ack = 1'b0; opb_dbus = '0;
        check("er_rsp_valid", 32'(rsp_valid), 1);
        check("er_status", 32'(rsp_status), 1);
        check("er_rdata", rsp_rdata, 0);
        tick();

        // Reset while in XFER aborts the transaction.
        issue(1'b0, 32'h0100_011C, 32'h0BAD_F00D);
        grant_now();
        check("ra_select", 32'(m_select), 1);
        rst = 1'b1; xfer_ack = 1'b1;
        tick();
        rst = 1'b0; xfer_ack = 1'b0;
        #1;
        check("ra_select_low", 32'(m_select), 0);
        check("ra_request_low", 32'(m_request), 0);
        check("ra_abus_low", m_abus, 0);
        check("ra_dbus_low", m_dbus, 0);
        check("ra_no_rsp", 32'(rsp_valid), 0);
        check("ra_status_clr", 32'(rsp_status), 0);
        check("ra_ready", 32'(cmd_ready), 1);
        tick();
        check("ra_no_rsp2", 32'(rsp_valid), 0);
        check("ra_ready2", 32'(cmd_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
